dense_sched: RTL and testbench

//  Sequencer for one fully-connected (dense) layer on the PE array. On start it latches the layer

---
 rtl/dense_sched_if.sv | 36 +++
 rtl/dense_sched.sv | 162 ++++++++++++++++
 tb/tb_dense_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dense_sched_if.sv
// Handshake/config bundle between the layer controller (master) and the dense-layer sequencer (slave).
interface dense_sched_if #(
  parameter int unsigned DIM_W  = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic [DIM_W-1:0]  cfg_in_len;
  logic [DIM_W-1:0]  cfg_out_len;
  logic [ADDR_W-1:0] cfg_in_base;
  logic [ADDR_W-1:0] cfg_w_base;
  logic [ADDR_W-1:0] cfg_out_base;
  logic              busy;
  logic              done;
  logic              buf1_rd_en;
  logic [ADDR_W-1:0] buf1_rd_addr;
  logic              buf2_rd_en;
  logic [ADDR_W-1:0] buf2_rd_addr;
  logic              pe_valid;
  logic              pe_clear;
  logic              pe_last;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_ready;

  modport master (
    output start, cfg_in_len, cfg_out_len, cfg_in_base, cfg_w_base, cfg_out_base, wb_ready,
    input  busy, done, buf1_rd_en, buf1_rd_addr, buf2_rd_en, buf2_rd_addr,
           pe_valid, pe_clear, pe_last, wb_en, wb_addr
  );

  modport slave (
    input  start, cfg_in_len, cfg_out_len, cfg_in_base, cfg_w_base, cfg_out_base, wb_ready,
    output busy, done, buf1_rd_en, buf1_rd_addr, buf2_rd_en, buf2_rd_addr,
           pe_valid, pe_clear, pe_last, wb_en, wb_addr
  );
endinterface

// File: rtl/dense_sched.sv
// Dense-layer sequencer: walks output tiles of NUM_PE neurons, streams activation/weight reads,
// aligns PE strobes to read latency and issues one write-back per tile.
module dense_sched #(
  parameter int unsigned NUM_PE = 8,
  parameter int unsigned DIM_W  = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  dense_sched_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  localparam logic [2:0] S_ZERO  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [DIM_W-1:0]  in_len_q, in_len_d;
  logic [DIM_W-1:0]  last_tile_q, last_tile_d;
  logic [DIM_W-1:0]  tile_q, tile_d;
  logic [DIM_W-1:0]  step_q, step_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d;
  logic [ADDR_W-1:0] a_ptr_q, a_ptr_d;
  logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              wb_en_q, wb_en_d;
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [RD_LAT-1:0] pc_q, pc_d;
  logic [RD_LAT-1:0] pl_q, pl_d;
  logic              hs;

  // Next state, pointers and registered output values
  always_comb begin
    state_d     = state_q;
    in_len_d    = in_len_q;
    last_tile_d = last_tile_q;
    tile_d      = tile_q;
    step_d      = step_q;
    in_base_d   = in_base_q;
    out_base_d  = out_base_q;
    a_ptr_d     = a_ptr_q;
    w_ptr_d     = w_ptr_q;
    hs          = (state_q == S_WB) && wb_en_q && bus.wb_ready;

    case (state_q)
      S_IDLE, S_FIN, S_ZERO: begin
        state_d = S_IDLE;
        if (bus.start) begin
          in_len_d    = bus.cfg_in_len;
          last_tile_d = DIM_W'((bus.cfg_out_len - DIM_W'(1)) / DIM_W'(NUM_PE));
          in_base_d   = bus.cfg_in_base;
          out_base_d  = bus.cfg_out_base;
          a_ptr_d     = bus.cfg_in_base;
          w_ptr_d     = bus.cfg_w_base;
          tile_d      = '0;
          step_d      = '0;
          state_d     = (bus.cfg_in_len == '0 || bus.cfg_out_len == '0) ? S_ZERO : S_RUN;
        end
      end
      S_RUN: begin
        // Weight pointer keeps running across tiles; activation pointer rewinds per tile
        w_ptr_d = w_ptr_q + ADDR_W'(1);
        if (step_q == in_len_q - DIM_W'(1)) begin
          state_d = S_DRAIN;
          step_d  = '0;
          a_ptr_d = in_base_q;
        end else begin
          step_d  = step_q + DIM_W'(1);
          a_ptr_d = a_ptr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (step_q == DIM_W'(RD_LAT - 1)) state_d = S_WB;
        else                              step_d  = step_q + DIM_W'(1);
      end
      S_WB: begin
        if (hs) begin
          tile_d = tile_q + DIM_W'(1);
          step_d = '0;
          state_d = (tile_q == last_tile_q) ? S_FIN : S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_en_d   = (state_d == S_RUN);
    first_d   = rd_en_d && (step_d == '0);
    last_d    = rd_en_d && (step_d == in_len_d - DIM_W'(1));
    wb_en_d   = (state_d == S_WB);
    wb_addr_d = wb_en_d ? out_base_d + ADDR_W'(tile_d) : '0;
    done_d    = (state_d == S_FIN) || (state_d == S_ZERO);
    busy_d    = !((state_d == S_IDLE) || (state_d == S_FIN) || (state_d == S_ZERO));
    pv_d      = RD_LAT'({pv_q, rd_en_q});
    pc_d      = RD_LAT'({pc_q, first_q});
    pl_d      = RD_LAT'({pl_q, last_q});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      in_len_q    <= '0;
      last_tile_q <= '0;
      tile_q      <= '0;
      step_q      <= '0;
      in_base_q   <= '0;
      out_base_q  <= '0;
      a_ptr_q     <= '0;
      w_ptr_q     <= '0;
      wb_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      wb_en_q     <= 1'b0;
      pv_q        <= '0;
      pc_q        <= '0;
      pl_q        <= '0;
    end else begin
      state_q     <= state_d;
      in_len_q    <= in_len_d;
      last_tile_q <= last_tile_d;
      tile_q      <= tile_d;
      step_q      <= step_d;
      in_base_q   <= in_base_d;
      out_base_q  <= out_base_d;
      a_ptr_q     <= a_ptr_d;
      w_ptr_q     <= w_ptr_d;
      wb_addr_q   <= wb_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      first_q     <= first_d;
      last_q      <= last_d;
      wb_en_q     <= wb_en_d;
      pv_q        <= pv_d;
      pc_q        <= pc_d;
      pl_q        <= pl_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.buf1_rd_en   = rd_en_q;
  assign bus.buf1_rd_addr = a_ptr_q;
  assign bus.buf2_rd_en   = rd_en_q;
  assign bus.buf2_rd_addr = w_ptr_q;
  assign bus.pe_valid     = pv_q[RD_LAT-1];
  assign bus.pe_clear     = pc_q[RD_LAT-1];
  assign bus.pe_last      = pl_q[RD_LAT-1];
  assign bus.wb_en        = wb_en_q;
  assign bus.wb_addr      = wb_addr_q;
endmodule

// File: tb/tb_dense_sched.sv
// Directed bench for dense_sched: table of layer configs with hand-computed counts/timing,
// plus a mid-layer reset sequence.
module tb_dense_sched;
  localparam int unsigned NUM_PE = 8;
  localparam int unsigned DIM_W  = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned RD_LAT = 2;
  localparam int LAT  = 2;
  localparam int MAXC = 200;
  localparam int NVEC = 8;

  typedef struct {
    int          in_len;
    int          out_len;
    logic [15:0] in_b;
    logic [15:0] w_b;
    logic [15:0] out_b;
    int          stall;
    bit          restart;
    int          e_rd;
    int          e_tiles;
    int          e_done;
    logic [15:0] e_wb_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [NVEC];

  dense_sched_if #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) bus ();

  dense_sched #(.NUM_PE(NUM_PE), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [55:0] all_outs();
    return {bus.busy, bus.done, bus.buf1_rd_en, bus.buf1_rd_addr, bus.buf2_rd_en, bus.buf2_rd_addr,
            bus.pe_valid, bus.pe_clear, bus.pe_last, bus.wb_en, bus.wb_addr};
  endfunction

  task automatic set_cfg(input int in_len, input int out_len,
                         input logic [15:0] a, input logic [15:0] w, input logic [15:0] o);
    bus.cfg_in_len   = 16'(in_len);
    bus.cfg_out_len  = 16'(out_len);
    bus.cfg_in_base  = a;
    bus.cfg_w_base   = w;
    bus.cfg_out_base = o;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int nrd, npe, nclr, nlst, nwb, ndone, done_c;
    int addr_err, pe_err, hold_err, busy_err, wcnt;
    logic [15:0] last_wb, prev_wb_addr;
    bit prev_wb_en, prev_hs, hs, rd, ev, ec, el, exp_busy;
    bit rd_h [0:MAXC];
    bit fr_h [0:MAXC];
    bit ls_h [0:MAXC];
    string tag;
    tag = $sformatf("v%0d", idx);
    nrd = 0; npe = 0; nclr = 0; nlst = 0; nwb = 0; ndone = 0; done_c = -1;
    addr_err = 0; pe_err = 0; hold_err = 0; busy_err = 0; wcnt = 0;
    last_wb = '0; prev_wb_addr = '0; prev_wb_en = 0; prev_hs = 0;
    for (int c = 0; c <= MAXC; c++) begin
      @(negedge clk);
      // sample outputs of cycle c
      rd = bus.buf1_rd_en;
      if (bus.buf1_rd_en !== bus.buf2_rd_en) addr_err++;
      rd_h[c] = rd;
      fr_h[c] = rd && (bus.buf1_rd_addr == v.in_b);
      ls_h[c] = rd && (bus.buf1_rd_addr == v.in_b + 16'(v.in_len - 1));
      if (rd) begin
        if (v.in_len > 0 && bus.buf1_rd_addr !== v.in_b + 16'(nrd % v.in_len)) addr_err++;
        if (bus.buf2_rd_addr !== v.w_b + 16'(nrd)) addr_err++;
        nrd++;
      end
      ev = (c >= LAT) ? rd_h[c-LAT] : 1'b0;
      ec = (c >= LAT) ? fr_h[c-LAT] : 1'b0;
      el = (c >= LAT) ? ls_h[c-LAT] : 1'b0;
      if ({bus.pe_valid, bus.pe_clear, bus.pe_last} !== {ev, ec, el}) pe_err++;
      if (bus.pe_valid === 1'b1) npe++;
      if (bus.pe_valid === 1'b1 && bus.pe_clear === 1'b1) nclr++;
      if (bus.pe_valid === 1'b1 && bus.pe_last === 1'b1) nlst++;
      exp_busy = (v.e_tiles > 0) && (c >= 1) && (c < v.e_done);
      if (bus.busy !== exp_busy) busy_err++;
      if (bus.busy === 1'b1 && bus.done === 1'b1) busy_err++;
      if (bus.done === 1'b1) begin
        ndone++;
        if (done_c < 0) done_c = c;
      end
      if (prev_wb_en && !prev_hs && (bus.wb_en !== 1'b1 || bus.wb_addr !== prev_wb_addr)) hold_err++;
      if (bus.wb_en === 1'b1 && rd) hold_err++;
      // drive inputs for the rest of cycle c
      bus.start = (c == 0) || (v.restart && c == 3);
      if (v.restart && c >= 2) set_cfg(7, 1, 16'h3000, 16'h4000, 16'h5000);
      else set_cfg(v.in_len, v.out_len, v.in_b, v.w_b, v.out_b);
      bus.wb_ready = (wcnt >= v.stall);
      hs = (bus.wb_en === 1'b1) && bus.wb_ready;
      if (hs) begin
        if (bus.wb_addr !== v.out_b + 16'(nwb)) addr_err++;
        last_wb = bus.wb_addr;
        nwb++;
      end
      wcnt = (bus.wb_en === 1'b1 && !hs) ? wcnt + 1 : 0;
      prev_wb_en = (bus.wb_en === 1'b1);
      prev_hs = hs;
      prev_wb_addr = bus.wb_addr;
      if (done_c >= 0 && c >= done_c + 3) break;
    end
    bus.start = 1'b0;
    bus.wb_ready = 1'b1;
    chk({tag, " rd_cnt"}, nrd, v.e_rd);
    chk({tag, " pe_cnt"}, npe, v.e_rd);
    chk({tag, " clear_cnt"}, nclr, v.e_tiles);
    chk({tag, " last_cnt"}, nlst, v.e_tiles);
    chk({tag, " wb_cnt"}, nwb, v.e_tiles);
    chk({tag, " done_cnt"}, ndone, 1);
    chk({tag, " done_cyc"}, done_c, v.e_done);
    chk({tag, " addr_err"}, addr_err, 0);
    chk({tag, " pe_align_err"}, pe_err, 0);
    chk({tag, " wb_hold_err"}, hold_err, 0);
    chk({tag, " busy_err"}, busy_err, 0);
    if (v.e_tiles > 0) chk({tag, " wb_last_addr"}, last_wb, v.e_wb_last);
  endtask

  // Reset asserted in cycle 5 of a running layer: outputs clear, nothing follows
  task automatic reset_mid();
    int act;
    @(negedge clk);
    set_cfg(4, 8, 16'h0010, 16'h0100, 16'h0200);
    bus.start = 1'b1;
    bus.wb_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("rst_busy_before", bus.busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outs_zero", all_outs(), 0);
    rst = 1'b1;
    act = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done || bus.wb_en || bus.buf1_rd_en || bus.pe_valid || bus.busy) act++;
    end
    chk("rst_quiet_after", act, 0);
  endtask

  initial begin
    //         in out in_b      w_b       out_b     stall rst  rd tiles done wb_last
    vecs[0] = '{4, 8,  16'h0010, 16'h0100, 16'h0200, 0, 1'b0, 4, 1,  8,  16'h0200};
    vecs[1] = '{3, 9,  16'h0010, 16'h0100, 16'h0200, 0, 1'b0, 6, 2,  13, 16'h0201};
    vecs[2] = '{4, 8,  16'h0010, 16'h0100, 16'h0200, 5, 1'b0, 4, 1,  13, 16'h0200};
    vecs[3] = '{0, 8,  16'h0010, 16'h0100, 16'h0200, 0, 1'b0, 0, 0,  1,  16'h0000};
    vecs[4] = '{4, 0,  16'h0010, 16'h0100, 16'h0200, 0, 1'b0, 0, 0,  1,  16'h0000};
    vecs[5] = '{4, 8,  16'h0010, 16'h0100, 16'h0200, 0, 1'b1, 4, 1,  8,  16'h0200};
    vecs[6] = '{1, 20, 16'h0040, 16'h0300, 16'h0500, 0, 1'b0, 3, 3,  13, 16'h0502};
    vecs[7] = '{2, 16, 16'hFFFF, 16'hFFFE, 16'hFFFF, 0, 1'b0, 4, 2,  11, 16'h0000};

    rst = 1'b0;
    bus.start = 1'b0;
    bus.wb_ready = 1'b1;
    set_cfg(0, 0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("reset_outs_zero", all_outs(), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);
    reset_mid();
    run_vec(99, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
